// File: rtl/rs_axis_slice.sv
// rs_axis_slice: parametrised AXI4-Stream register slice with idle flag and
// wrapping tlast counter. s_axis_* in, m_axis_* out, pkt_cnt/pkt_cnt_clr, idle.
module rs_axis_slice #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 16,
  parameter int USER_W = 137,
  parameter int STAGES = 1,
  parameter int MODE   = 1
) (
  input  logic              user_clk,
  input  logic              reset_n,
  input  logic              s_axis_tvalid,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  input  logic              pkt_cnt_clr,
  output logic [31:0]       pkt_cnt,
  output logic              idle
);

  localparam int PW = DATA_W + KEEP_W + USER_W + 1;

  logic [PW-1:0] s_pl;
  logic [PW-1:0] m_pl;
  logic [31:0]   cnt_q;

  assign s_pl = {s_axis_tdata, s_axis_tkeep,
                 s_axis_tuser, s_axis_tlast};
  assign {m_axis_tdata, m_axis_tkeep,
          m_axis_tuser, m_axis_tlast} = m_pl;

  generate
    if (MODE < 0 || MODE > 2 ||
        STAGES < 1 || STAGES > 4) begin : g_bad
      $error("rs_axis_slice: illegal MODE/STAGES");
    end

    if (MODE == 0) begin : g_byp
      assign m_pl          = s_pl;
      assign m_axis_tvalid = s_axis_tvalid;
      assign s_axis_tready = m_axis_tready;
      assign idle          = ~s_axis_tvalid;
    end else begin : g_pipe
      logic [PW-1:0]     pl [STAGES+1];
      logic [STAGES:0]   vl;
      logic [STAGES-1:0] rd;
      logic [STAGES-1:0] bz;

      assign pl[0]         = s_pl;
      assign vl[0]         = s_axis_tvalid;
      assign s_axis_tready = rd[0];
      assign m_pl          = pl[STAGES];
      assign m_axis_tvalid = vl[STAGES];
      assign idle          = ~|bz;

      for (genvar k = 0; k < STAGES; k++) begin : g_stg
        if (MODE == 1) begin : g_fwd
          logic          v_q;
          logic [PW-1:0] p_q;

          // Unrolled ready chain: stage k can take a beat
          // unless it and every stage after it is full
          // and the sink is stalled.
          assign rd[k] = m_axis_tready |
                         ~(&bz[STAGES-1:k]);

          always_ff @(posedge user_clk or negedge reset_n) begin
            if (!reset_n) begin
              v_q <= 1'b0;
              p_q <= '0;
            end else if (rd[k]) begin
              v_q <= vl[k];
              p_q <= pl[k];
            end
          end

          assign vl[k+1] = v_q;
          assign pl[k+1] = p_q;
          assign bz[k]   = v_q;
        end else begin : g_full
          logic          m_v;
          logic          s_v;
          logic          r_q;
          logic [PW-1:0] m_p;
          logic [PW-1:0] s_p;
          logic          o_rdy;
          logic          acc;

          if (k == STAGES-1) begin : g_last
            assign o_rdy = m_axis_tready;
          end else begin : g_mid
            assign o_rdy = rd[k+1];
          end

          assign acc = vl[k] & r_q;

          // r_q mirrors the next skid state, so ready is
          // low in exactly the cycles the skid is full.
          always_ff @(posedge user_clk or negedge reset_n) begin
            if (!reset_n) begin
              m_v <= 1'b0;
              s_v <= 1'b0;
              r_q <= 1'b0;
              m_p <= '0;
              s_p <= '0;
            end else begin
              r_q <= 1'b1;
              unique case (1'b1)
                ~m_v: begin
                  if (acc) begin
                    m_v <= 1'b1;
                    m_p <= pl[k];
                  end
                end
                m_v & ~s_v: begin
                  if (o_rdy) begin
                    if (acc) m_p <= pl[k];
                    else     m_v <= 1'b0;
                  end else if (acc) begin
                    s_v <= 1'b1;
                    s_p <= pl[k];
                    r_q <= 1'b0;
                  end
                end
                default: begin
                  if (o_rdy) begin
                    m_p <= s_p;
                    s_v <= 1'b0;
                  end else begin
                    r_q <= 1'b0;
                  end
                end
              endcase
            end
          end

          assign rd[k]   = r_q;
          assign vl[k+1] = m_v;
          assign pl[k+1] = m_p;
          assign bz[k]   = m_v | s_v;
        end
      end
    end
  endgenerate

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (pkt_cnt_clr) begin
      cnt_q <= '0;
    end else if (m_axis_tvalid & m_axis_tready &
                 m_axis_tlast) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign pkt_cnt = cnt_q;

endmodule
